// File: rtl/md_unit.sv
// Iterative radix-2 multiply/divide unit for the EX stage.
// Results are returned as a HI/LO pair: product halves, or remainder/quotient.
module md_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             op_div_i,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] opdata1_i,
    input  logic [WIDTH-1:0] opdata2_i,
    input  logic             annul_i,
    output logic             busy_o,
    output logic             ready_o,
    output logic [WIDTH-1:0] result_hi_o,
    output logic [WIDTH-1:0] result_lo_o
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt;
    logic               op_div, neg_a, neg_b;
    logic [WIDTH-1:0]   opnd;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   hi_q, lo_q;

    logic [WIDTH-1:0]   mag1, mag2;
    logic               div_zero;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_nx, prod_fix;
    logic [WIDTH:0]     div_sh, div_diff;
    logic               q_bit;
    logic [WIDTH-1:0]   rem_nx, quo_nx, rem_fix, quo_fix;

    always_comb begin
        mag1     = (signed_i && opdata1_i[WIDTH-1]) ? ('0 - opdata1_i) : opdata1_i;
        mag2     = (signed_i && opdata2_i[WIDTH-1]) ? ('0 - opdata2_i) : opdata2_i;
        div_zero = op_div_i && (opdata2_i == '0);

        // Multiply: multiplier sits in acc low half and is consumed from bit 0
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : {WIDTH{1'b0}})};
        mul_nx   = {mul_sum, acc[WIDTH-1:1]};
        prod_fix = (neg_a ^ neg_b) ? ('0 - mul_nx) : mul_nx;

        // Divide: acc low half shifts dividend out and quotient in; div_sh is
        // the WIDTH+1-bit partial remainder, stored remainder is always < divisor
        div_sh   = {rem, acc[WIDTH-1]};
        div_diff = div_sh - {1'b0, opnd};
        q_bit    = ~div_diff[WIDTH];
        rem_nx   = q_bit ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
        quo_nx   = {acc[WIDTH-2:0], q_bit};
        quo_fix  = (neg_a ^ neg_b) ? ('0 - quo_nx) : quo_nx;
        rem_fix  = neg_a ? ('0 - rem_nx) : rem_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (start_i && !annul_i) state_nx = div_zero ? DONE : CALC;
            CALC: begin
                if (annul_i)                 state_nx = IDLE;
                else if (cnt == CNT_W'(1))   state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            op_div <= 1'b0;
            neg_a  <= 1'b0;
            neg_b  <= 1'b0;
            opnd   <= '0;
            acc    <= '0;
            rem    <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (start_i && !annul_i) begin
                        if (div_zero) begin
                            hi_q <= opdata1_i;
                            lo_q <= '1;
                        end else begin
                            op_div <= op_div_i;
                            neg_a  <= signed_i & opdata1_i[WIDTH-1];
                            neg_b  <= signed_i & opdata2_i[WIDTH-1];
                            opnd   <= op_div_i ? mag2 : mag1;
                            acc    <= {{WIDTH{1'b0}}, (op_div_i ? mag1 : mag2)};
                            rem    <= '0;
                            cnt    <= CNT_W'(WIDTH);
                        end
                    end
                end
                CALC: begin
                    if (!annul_i) begin
                        cnt <= cnt - CNT_W'(1);
                        if (op_div) begin
                            acc[WIDTH-1:0] <= quo_nx;
                            rem            <= rem_nx;
                        end else begin
                            acc <= mul_nx;
                        end
                        if (cnt == CNT_W'(1)) begin
                            if (op_div) begin
                                hi_q <= rem_fix;
                                lo_q <= quo_fix;
                            end else begin
                                hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                                lo_q <= prod_fix[WIDTH-1:0];
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy_o      = (state == CALC);
    assign ready_o     = (state == DONE);
    assign result_hi_o = hi_q;
    assign result_lo_o = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: 32-bit and 8-bit instances share one stimulus stream.
module tb_md_unit;

    logic        clk = 1'b0;
    logic        rst, start, op_div, sgn, annul;
    logic [31:0] op1, op2;
    logic        busy, ready, busy8, ready8;
    logic [31:0] hi, lo;
    logic [7:0]  hi8, lo8;

    int total = 0;
    int bad = 0;
    int lat, lat8, busy_cnt, overlap = 0;

    always #5 clk = ~clk;

    md_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start_i(start), .op_div_i(op_div), .signed_i(sgn),
        .opdata1_i(op1), .opdata2_i(op2), .annul_i(annul),
        .busy_o(busy), .ready_o(ready), .result_hi_o(hi), .result_lo_o(lo)
    );

    md_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start_i(start), .op_div_i(op_div), .signed_i(sgn),
        .opdata1_i(op1[7:0]), .opdata2_i(op2[7:0]), .annul_i(annul),
        .busy_o(busy8), .ready_o(ready8), .result_hi_o(hi8), .result_lo_o(lo8)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Start an op; optionally annul/restart/reset at a given cycle after the start edge.
    task automatic do_op(input logic div, input logic sg, input logic [31:0] a, input logic [31:0] b,
                         input logic annul_start, input int annul_at, input int start_at, input int rst_at);
        @(posedge clk); #1;
        start = 1'b1; op_div = div; sgn = sg; op1 = a; op2 = b; annul = annul_start;
        @(posedge clk); #1;
        start = 1'b0; annul = 1'b0; op1 = 32'hA5A5_5A5A; op2 = 32'h0; op_div = ~div; sgn = ~sg;
        lat = 0; lat8 = 0; busy_cnt = 0;
        for (int c = 1; c <= 60; c++) begin
            annul = (c == annul_at);
            rst   = (c == rst_at);
            start = (c == start_at);
            @(negedge clk);
            if (busy) busy_cnt++;
            if ((busy && ready) || (busy8 && ready8)) overlap++;
            if (ready8 && lat8 == 0) lat8 = c;
            if (ready) begin
                lat = c;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic res32(input string tag, input logic [31:0] eh, input logic [31:0] el, input int elat);
        check({tag, "_lat"}, 64'(lat), 64'(elat));
        check({tag, "_hi"}, {32'h0, hi}, {32'h0, eh});
        check({tag, "_lo"}, {32'h0, lo}, {32'h0, el});
    endtask

    task automatic res8(input string tag, input logic [7:0] eh, input logic [7:0] el, input int elat);
        check({tag, "_lat8"}, 64'(lat8), 64'(elat));
        check({tag, "_hi8"}, {56'h0, hi8}, {56'h0, eh});
        check({tag, "_lo8"}, {56'h0, lo8}, {56'h0, el});
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op_div = 1'b0; sgn = 1'b0; annul = 1'b0;
        op1 = '0; op2 = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_busy", {63'h0, busy}, 64'h0);
        check("rst_ready", {63'h0, ready}, 64'h0);
        check("rst_hi", {32'h0, hi}, 64'h0);
        check("rst_lo", {32'h0, lo}, 64'h0);

        do_op(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, 0, 0);
        res32("umul_ff", 32'hFFFF_FFFE, 32'h0000_0001, 33);
        check("umul_ff_busy", 64'(busy_cnt), 64'd32);
        res8("umul_ff", 8'hFE, 8'h01, 9);

        do_op(1'b1, 1'b1, 32'hFFFF_FFF9, 32'h2, 1'b0, 0, 0, 0);
        res32("sdiv_m7_2", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
        res8("sdiv_m7_2", 8'hFF, 8'hFD, 9);

        do_op(1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, 0, 0);
        res32("smul_m1_m1", 32'h0, 32'h1, 33);
        res8("smul_m1_m1", 8'h00, 8'h01, 9);

        do_op(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0, 0, 0);
        res32("sdiv_minneg", 32'h0, 32'h8000_0000, 33);

        do_op(1'b1, 1'b0, 32'd100, 32'd7, 1'b0, 0, 0, 0);
        res32("udiv_100_7", 32'd2, 32'd14, 33);
        res8("udiv_100_7", 8'h02, 8'h0E, 9);

        do_op(1'b1, 1'b0, 32'd100, 32'd0, 1'b0, 0, 0, 0);
        res32("udiv_by0", 32'h64, 32'hFFFF_FFFF, 1);
        check("udiv_by0_busy", 64'(busy_cnt), 64'd0);
        res8("udiv_by0", 8'h64, 8'hFF, 1);

        do_op(1'b1, 1'b1, 32'd100, 32'd0, 1'b0, 0, 0, 0);
        res32("sdiv_by0", 32'h64, 32'hFFFF_FFFF, 1);
        check("sdiv_by0_busy", 64'(busy_cnt), 64'd0);

        do_op(1'b0, 1'b1, 32'hFFFF_FFFD, 32'd5, 1'b0, 0, 0, 0);
        res32("smul_m3_5", 32'hFFFF_FFFF, 32'hFFFF_FFF1, 33);
        res8("smul_m3_5", 8'hFF, 8'hF1, 9);

        do_op(1'b1, 1'b1, 32'd7, 32'hFFFF_FFFE, 1'b0, 0, 0, 0);
        res32("sdiv_7_m2", 32'd1, 32'hFFFF_FFFD, 33);
        res8("sdiv_7_m2", 8'h01, 8'hFD, 9);

        do_op(1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2, 1'b0, 0, 0, 0);
        res32("udiv_big_2", 32'd1, 32'h7FFF_FFFC, 33);
        res8("udiv_big_2", 8'h01, 8'h7C, 9);

        do_op(1'b0, 1'b0, 32'h8000_0000, 32'd2, 1'b0, 0, 0, 0);
        res32("umul_carry", 32'd1, 32'd0, 33);

        do_op(1'b1, 1'b1, 32'hFFFF_FF9C, 32'd7, 1'b0, 0, 0, 0);
        res32("sdiv_m100_7", 32'hFFFF_FFFE, 32'hFFFF_FFF2, 33);
        res8("sdiv_m100_7", 8'hFE, 8'hF2, 9);

        // annul in CALC: idle from cycle 11, previous results kept
        do_op(1'b0, 1'b0, 32'd3, 32'd3, 1'b0, 10, 0, 0);
        res32("annul_calc", 32'hFFFF_FFFE, 32'hFFFF_FFF2, 0);
        check("annul_calc_busy", 64'(busy_cnt), 64'd10);
        res8("annul_calc", 8'h00, 8'h09, 9);

        do_op(1'b1, 1'b0, 32'd100, 32'd7, 1'b0, 0, 5, 0);
        res32("start_in_calc", 32'd2, 32'd14, 33);

        do_op(1'b0, 1'b0, 32'd5, 32'd5, 1'b1, 0, 0, 0);
        res32("annul_idle", 32'd2, 32'd14, 0);
        check("annul_idle_busy", 64'(busy_cnt), 64'd0);

        do_op(1'b0, 1'b0, 32'd6, 32'd7, 1'b0, 33, 0, 0);
        res32("annul_done", 32'd0, 32'd42, 33);

        do_op(1'b0, 1'b0, 32'h1234_5678, 32'h10, 1'b0, 0, 0, 0);
        res32("back2back", 32'd1, 32'h2345_6780, 33);

        do_op(1'b1, 1'b1, 32'd100, 32'd7, 1'b0, 0, 0, 5);
        res32("rst_mid", 32'd0, 32'd0, 0);
        check("rst_mid_busycnt", 64'(busy_cnt), 64'd5);
        check("rst_mid_busy", {63'h0, busy}, 64'h0);
        check("rst_mid_ready", {63'h0, ready}, 64'h0);
        check("rst_mid_hi8", {56'h0, hi8}, 64'h0);
        check("rst_mid_lo8", {56'h0, lo8}, 64'h0);

        do_op(1'b0, 1'b1, 32'd7, 32'hFFFF_FFFE, 1'b0, 0, 0, 0);
        res32("smul_after_rst", 32'hFFFF_FFFF, 32'hFFFF_FFF2, 33);

        check("busy_ready_excl", 64'(overlap), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/md_unit.md
# md_unit

Parametrised iterative multiply/divide unit for the EX stage, successor to the fixed 32-bit divider. One start/ready handshake serves signed and unsigned multiply and divide at configurable operand width. Results are returned as a HI/LO pair for the hilo register path. EX holds its stall request while `busy_o` is high and consumes `result_hi_o`/`result_lo_o` on `ready_o`.

## Interface
- `WIDTH`, 32: operand width in bits; must be ≥ 4 and even.
- `CNT_W`, `$clog2(WIDTH+1)`: iteration counter width; derived, not overridden.

Ports:
- `clk` in 1: the single clock; all state changes on its rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `start_i` in 1: request a new operation; sampled only in IDLE.
- `op_div_i` in 1: 1 selects divide, 0 selects multiply; sampled with `start_i`.
- `signed_i` in 1: 1 selects signed two's-complement, 0 selects unsigned; sampled with `start_i`.
- `opdata1_i` in WIDTH: multiplicand or dividend.
- `opdata2_i` in WIDTH: multiplier or divisor.
- `annul_i` in 1: abort the current operation.
- `busy_o` out 1: operation in progress (CALC).
- `ready_o` out 1: one-cycle pulse; results valid.
- `result_hi_o` out WIDTH: product high half, or remainder.
- `result_lo_o` out WIDTH: product low half, or quotient.

## Operation
- FSM states: IDLE, CALC, DONE. Reset forces IDLE, counter 0, all internal registers 0, and all outputs 0.
- IDLE to CALC: on `start_i`=1, latch op, sign mode, and the operand magnitudes. In signed mode, a negative operand is negated modulo 2^WIDTH. Latch result-sign flags. Load counter = WIDTH.
- IDLE to DONE directly: on `start_i`, divide, and `opdata2_i`=0. Results are HI = `opdata1_i` (raw) and LO = all ones. This holds for both signed and unsigned divide.
- CALC, multiply: radix-2 shift-add, one multiplier bit per cycle, into a 2·WIDTH accumulator.
- CALC, divide: radix-2 restoring division, one quotient bit per cycle. The partial remainder is WIDTH+1 bits wide.
- Each CALC cycle decrements the counter. When the counter reaches 1, the FSM goes to DONE.
- Entering DONE: apply the sign fix-up, then register the results.
  - Signed multiply: negate the 2·WIDTH product if the operand signs differ.
  - Signed divide: negate the quotient if the operand signs differ. Negate the remainder if the dividend is negative.
- Most-negative ÷ −1 needs no special case. It yields quotient = 100…0 and remainder = 0.
- DONE: `ready_o`=1 for exactly this cycle, then the FSM goes to IDLE unconditionally.
- `result_hi_o`/`result_lo_o` hold their values from DONE until the next DONE or `rst`. `annul_i` does not clear them.
- `start_i` asserted outside IDLE is ignored. Operand inputs are don't-care outside the start cycle.
- `annul_i`=1 in CALC: go to IDLE next cycle, with no `ready_o` and results unchanged.
- `annul_i`=1 in IDLE: takes priority over `start_i`; the start is dropped.
- `annul_i`=1 in DONE: has no effect; `ready_o` still pulses.
- `rst` asserted mid-operation: IDLE next cycle and outputs zeroed, same as power-on.

## Timing
- Start sampled at edge 0. `busy_o` is high for cycles 1..WIDTH. `ready_o` is high in cycle WIDTH+1, which is 33 for WIDTH=32.
- Divide by zero: `ready_o` is high in cycle 1, and `busy_o` never rises.
- Back-to-back operations: the earliest next start is sampled in the cycle after DONE. Throughput is one operation per WIDTH+2 cycles.
- `busy_o` is a registered state decode, with no combinational path from inputs.
- `ready_o` and the result registers update on the same edge.
- `busy_o` and `ready_o` are never both high.

## Test plan
- Unsigned multiply, 0xFFFFFFFF × 0xFFFFFFFF: `ready_o` at cycle 33, HI = 0xFFFFFFFE, LO = 0x00000001. The preceding 32 cycles show `busy_o`=1.
- Signed divide, −7 ÷ 2 (0xFFFFFFF9, 0x00000002): LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. Signed multiply, −1 × −1: HI = 0, LO = 1.
- Signed divide, 0x80000000 ÷ 0xFFFFFFFF: LO = 0x80000000, HI = 0. Unsigned divide, 100 ÷ 7: LO = 14, HI = 2.
- Divide by zero, 100 ÷ 0 (signed and unsigned): `ready_o` at cycle 1, HI = 0x64, LO = 0xFFFFFFFF, `busy_o` stays 0.
- Annul: start a multiply, assert `annul_i` at cycle 10. Expect IDLE at cycle 11, no `ready_o` for the following 40 cycles, and results equal to the previous operation's. Also: `start_i` pulsed during CALC is ignored, and `rst` at cycle 5 zeroes all outputs.
- Parameter sweep: WIDTH=8 and WIDTH=64, 1000 random operands per op/sign mode against a reference model. Also check a latency of WIDTH+1 and a back-to-back start accepted exactly one cycle after `ready_o`.
